// File: rtl/popcount_accum_threshold.sv
// Accumulates BEATS clamped popcount beats into one vector sum and emits the sum
// together with an inclusive threshold activation bit over a valid/ready handshake.
module popcount_accum_threshold #(
    parameter int DATA_WIDTH = 256,
    parameter int CNT_WIDTH  = 9,
    parameter int BEATS      = 4,
    parameter int ACC_WIDTH  = 11,
    parameter int BEAT_W     = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [CNT_WIDTH-1:0] pop_count,
    input  logic [ACC_WIDTH-1:0] threshold,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_sum,
    output logic                 out_bit,
    output logic                 ovf_err
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [CNT_WIDTH-1:0] MAX_CNT   = CNT_WIDTH'(DATA_WIDTH);
    localparam logic [BEAT_W-1:0]    LAST_BEAT = BEAT_W'(BEATS - 1);

    logic [1:0]           state_q, state_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [BEAT_W-1:0]    beat_q, beat_d;
    logic [ACC_WIDTH-1:0] thr_q, thr_d;
    logic [ACC_WIDTH-1:0] sum_q, sum_d;
    logic                 bit_q, bit_d;
    logic                 ovf_q, ovf_d;

    logic                 accept;
    logic                 pop_over;
    logic [ACC_WIDTH-1:0] pop_ext;
    logic [ACC_WIDTH-1:0] acc_add;

    // Saturates an out-of-range beat count to the largest legal popcount.
    function automatic logic [CNT_WIDTH-1:0] clamp_cnt(input logic [CNT_WIDTH-1:0] c);
        return (c > MAX_CNT) ? MAX_CNT : c;
    endfunction

    assign in_ready  = (state_q != ST_DONE);
    assign out_valid = (state_q == ST_DONE);
    assign out_sum   = sum_q;
    assign out_bit   = bit_q;
    assign ovf_err   = ovf_q;

    assign accept   = in_valid && in_ready && !clear;
    assign pop_over = (pop_count > MAX_CNT);
    assign pop_ext  = ACC_WIDTH'(clamp_cnt(pop_count));
    assign acc_add  = acc_q + pop_ext;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        beat_d  = beat_q;
        thr_d   = thr_q;
        sum_d   = sum_q;
        bit_d   = bit_q;
        ovf_d   = ovf_q | (accept && pop_over);

        // Abort wins over every handshake, including a beat offered this cycle.
        if (clear) begin
            state_d = ST_IDLE;
            acc_d   = '0;
            beat_d  = '0;
            sum_d   = '0;
            bit_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        acc_d  = pop_ext;
                        thr_d  = threshold;
                        beat_d = BEAT_W'(1);
                        if (BEATS == 1) begin
                            state_d = ST_DONE;
                            sum_d   = pop_ext;
                            bit_d   = (pop_ext >= threshold);
                        end else begin
                            state_d = ST_ACCUM;
                        end
                    end
                end
                ST_ACCUM: begin
                    if (in_valid) begin
                        acc_d  = acc_add;
                        beat_d = beat_q + BEAT_W'(1);
                        if (beat_q == LAST_BEAT) begin
                            state_d = ST_DONE;
                            sum_d   = acc_add;
                            bit_d   = (acc_add >= thr_q);
                        end
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_d = ST_IDLE;
                        acc_d   = '0;
                        beat_d  = '0;
                        sum_d   = '0;
                        bit_d   = 1'b0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    acc_d   = '0;
                    beat_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            beat_q  <= '0;
            thr_q   <= '0;
            sum_q   <= '0;
            bit_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            beat_q  <= beat_d;
            thr_q   <= thr_d;
            sum_q   <= sum_d;
            bit_q   <= bit_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_popcount_accum_threshold.sv
// Randomised self-checking bench for popcount_accum_threshold against a
// vector-level model: sum of saturated beats, inclusive threshold, sticky overflow.
module tb_popcount_accum_threshold;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [8:0]  pop_count = '0;
    logic [10:0] threshold = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [10:0] out_sum;
    logic        out_bit;
    logic        ovf_err;

    int checks = 0;
    int errors = 0;
    bit ovf_model = 1'b0;

    popcount_accum_threshold dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .pop_count (pop_count),
        .threshold (threshold),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_bit   (out_bit),
        .ovf_err   (ovf_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500us;
        $display("FAIL timeout: simulation did not complete, got running required finished");
        $fatal(1, "timeout");
    end

    function automatic int model_sum(input int p[4]);
        int s = 0;
        for (int i = 0; i < 4; i++) s += (p[i] > 256) ? 256 : p[i];
        return s;
    endfunction

    function automatic bit model_any_ovf(input int p[4]);
        bit o = 1'b0;
        for (int i = 0; i < 4; i++) if (p[i] > 256) o = 1'b1;
        return o;
    endfunction

    // Offers four beats; threshold is only meaningful on the first one.
    task automatic drive_vector(input int p[4], input int thr, input bit bubbles);
        for (int i = 0; i < 4; i++) begin
            if (bubbles) begin
                @(negedge clk);
                in_valid  = 1'b0;
                threshold = 11'($urandom_range(0, 2047));
            end
            @(negedge clk);
            in_valid  = 1'b1;
            pop_count = 9'(p[i]);
            threshold = (i == 0) ? 11'(thr) : 11'($urandom_range(0, 2047));
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL beat_ready: beat %0d in_ready=%b required 1", i, in_ready);
            end
            @(posedge clk);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        threshold = 11'($urandom_range(0, 2047));
        ovf_model = ovf_model | model_any_ovf(p);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({out_valid, out_sum, out_bit, ovf_err, in_ready} !== {1'b0, 11'd0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset: valid=%b sum=%0d bit=%b ovf=%b rdy=%b required 0 0 0 0 1",
                     out_valid, out_sum, out_bit, ovf_err, in_ready);
        end
    endtask

    task automatic test_full_scale;
        int p[4] = '{256, 256, 256, 256};
        out_ready = 1'b1;
        drive_vector(p, 1024, 1'b0);
        checks++;
        if ({out_valid, out_sum, out_bit, in_ready} !== {1'b1, 11'd1024, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL full_scale: valid=%b sum=%0d bit=%b rdy=%b required 1 1024 1 0",
                     out_valid, out_sum, out_bit, in_ready);
        end
        @(negedge clk);
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL full_scale_one_cycle: valid=%b rdy=%b required 0 1", out_valid, in_ready);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_bubbles;
        int p[4] = '{10, 20, 30, 40};
        int thr[2] = '{101, 100};
        for (int v = 0; v < 2; v++) begin
            out_ready = 1'b0;
            drive_vector(p, thr[v], 1'b1);
            checks++;
            if ({out_valid, out_sum, out_bit} !== {1'b1, 11'(model_sum(p)), (model_sum(p) >= thr[v])}) begin
                errors++;
                $display("FAIL bubbles_thr%0d: valid=%b sum=%0d bit=%b required 1 %0d %b", thr[v],
                         out_valid, out_sum, out_bit, model_sum(p), (model_sum(p) >= thr[v]));
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
    endtask

    task automatic test_backpressure;
        int p[4] = '{3, 90, 200, 5};
        int q[4] = '{1, 2, 3, 4};
        out_ready = 1'b0;
        drive_vector(p, 298, 1'b0);
        for (int c = 0; c < 5; c++) begin
            in_valid  = 1'b1;
            pop_count = 9'd7;
            threshold = 11'($urandom_range(0, 2047));
            checks++;
            if ({out_valid, out_sum, out_bit, in_ready} !== {1'b1, 11'd298, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL backpressure_hold%0d: valid=%b sum=%0d bit=%b rdy=%b required 1 298 1 0",
                         c, out_valid, out_sum, out_bit, in_ready);
            end
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_release: valid=%b required 0", out_valid);
        end
        drive_vector(q, 11, 1'b0);
        checks++;
        if ({out_valid, out_sum, out_bit} !== {1'b1, 11'd10, 1'b0}) begin
            errors++;
            $display("FAIL backpressure_next: valid=%b sum=%0d bit=%b required 1 10 0",
                     out_valid, out_sum, out_bit);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_overflow;
        int p[4] = '{0, 300, 0, 0};
        int q[4] = '{5, 5, 5, 5};
        drive_vector(p, 256, 1'b0);
        checks++;
        if ({out_valid, out_sum, out_bit, ovf_err} !== {1'b1, 11'd256, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL overflow: valid=%b sum=%0d bit=%b ovf=%b required 1 256 1 1",
                     out_valid, out_sum, out_bit, ovf_err);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        drive_vector(q, 21, 1'b0);
        checks++;
        if ({out_sum, out_bit, ovf_err} !== {11'd20, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL overflow_sticky: sum=%0d bit=%b ovf=%b required 20 0 1", out_sum, out_bit, ovf_err);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_clear;
        int q[4] = '{1, 1, 1, 1};
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            in_valid  = 1'b1;
            pop_count = 9'd50;
            threshold = 11'd0;
            @(posedge clk);
        end
        @(negedge clk);
        clear     = 1'b1;
        pop_count = 9'd50;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL clear_ready: rdy=%b required 1", in_ready);
        end
        @(negedge clk);
        clear    = 1'b0;
        in_valid = 1'b0;
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL clear_idle: valid=%b rdy=%b required 0 1", out_valid, in_ready);
        end
        drive_vector(q, 3, 1'b0);
        checks++;
        if ({out_valid, out_sum, out_bit, ovf_err} !== {1'b1, 11'd4, 1'b1, ovf_model}) begin
            errors++;
            $display("FAIL clear_restart: valid=%b sum=%0d bit=%b ovf=%b required 1 4 1 %b",
                     out_valid, out_sum, out_bit, ovf_err, ovf_model);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_random;
        int p[4];
        int thr;
        int s;
        int hold;
        for (int v = 0; v < 24; v++) begin
            for (int i = 0; i < 4; i++)
                p[i] = ($urandom_range(0, 7) == 0) ? int'($urandom_range(257, 511)) : int'($urandom_range(0, 256));
            s    = model_sum(p);
            thr  = ($urandom_range(0, 3) == 0) ? s : int'($urandom_range(0, 1100));
            hold = $urandom_range(0, 3);
            drive_vector(p, thr, 1'($urandom_range(0, 1)));
            checks++;
            if ({out_valid, out_sum, out_bit, ovf_err} !== {1'b1, 11'(s), (s >= thr), ovf_model}) begin
                errors++;
                $display("FAIL random_v%0d: valid=%b sum=%0d bit=%b ovf=%b required 1 %0d %b %b",
                         v, out_valid, out_sum, out_bit, ovf_err, s, (s >= thr), ovf_model);
            end
            repeat (hold) @(negedge clk);
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            checks++;
            if ({out_valid, in_ready} !== 2'b01) begin
                errors++;
                $display("FAIL random_handshake_v%0d: valid=%b rdy=%b required 0 1", v, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_async_reset;
        int p[4] = '{100, 100, 100, 100};
        int q[4] = '{7, 8, 9, 10};
        out_ready = 1'b0;
        drive_vector(p, 50, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_sum, out_bit, ovf_err, in_ready} !== {1'b0, 11'd0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL async_reset: valid=%b sum=%0d bit=%b ovf=%b rdy=%b required 0 0 0 0 1",
                     out_valid, out_sum, out_bit, ovf_err, in_ready);
        end
        @(negedge clk);
        rst_n     = 1'b1;
        ovf_model = 1'b0;
        drive_vector(q, 34, 1'b0);
        checks++;
        if ({out_valid, out_sum, out_bit, ovf_err} !== {1'b1, 11'd34, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL async_reset_resume: valid=%b sum=%0d bit=%b ovf=%b required 1 34 1 0",
                     out_valid, out_sum, out_bit, ovf_err);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_full_scale();
        test_bubbles();
        test_backpressure();
        test_overflow();
        test_clear();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
